// File: rtl/cs_pred_seq_if.sv
// Handshake and data bundle between the intra-prediction sequencer and its neighbours.
// master = upstream sample source / downstream consumer side, slave = the sequencer.
`timescale 1ns/1ps
interface cs_pred_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  left_avail;
    logic                  up_avail;
    logic                  busy;
    logic                  edge_sel;
    logic                  smp_valid;
    logic [DATA_WIDTH-1:0] smp_data;
    logic                  smp_ready;
    logic                  avg_valid;
    logic                  avg_ack;
    logic [DATA_WIDTH-1:0] avg_y_left_out;
    logic [DATA_WIDTH-1:0] avg_y_up_out;
    logic [DATA_WIDTH-1:0] avg_y_dc_out;

    modport master (
        output start, left_avail, up_avail, smp_valid, smp_data, avg_ack,
        input  busy, edge_sel, smp_ready, avg_valid,
        input  avg_y_left_out, avg_y_up_out, avg_y_dc_out
    );

    modport slave (
        input  start, left_avail, up_avail, smp_valid, smp_data, avg_ack,
        output busy, edge_sel, smp_ready, avg_valid,
        output avg_y_left_out, avg_y_up_out, avg_y_dc_out
    );
endinterface

// File: rtl/cs_pred_seq.sv
// Purpose: collects left/up neighbour samples per block and produces rounded left/up/DC averages.
// Latency: 2 + 8 per available edge cycles from start to avg_valid with no sample stalls.
// Backpressure: smp_valid gaps stall accumulation; averages are held in OUT until avg_ack.
`timescale 1ns/1ps
module cs_pred_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_N     = 3,
    parameter int DC_DEFAULT = 128
) (
    input  logic           clk,
    input  logic           rst,
    cs_pred_seq_if.slave   bus
);
    localparam int ACC_W = DATA_WIDTH + LOG2_N;
    localparam logic [ACC_W-1:0] RND = ACC_W'(1 << (LOG2_N - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEFT,
        S_UP,
        S_CALC,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] up;
        logic [DATA_WIDTH-1:0] dc;
    } avg_t;

    state_t             state_q, state_d;
    logic [LOG2_N-1:0]  cnt_q;
    logic [ACC_W-1:0]   acc_l_q, acc_u_q;
    logic               left_f_q, up_f_q;
    avg_t               avg_q, avg_d;

    logic               smp_rdy;
    logic               accept;
    logic               last_acc;
    logic [ACC_W-1:0]   smp_ext;

    logic [DATA_WIDTH-1:0] avg_l_c, avg_u_c, avg_dc_c;
    logic [DATA_WIDTH:0]   dc_sum;

    assign smp_rdy  = (state_q == S_LEFT) || (state_q == S_UP);
    assign accept   = smp_rdy && bus.smp_valid;
    assign last_acc = accept && (&cnt_q);
    assign smp_ext  = {{LOG2_N{1'b0}}, bus.smp_data};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.left_avail)    state_d = S_LEFT;
                    else if (bus.up_avail) state_d = S_UP;
                    else                   state_d = S_CALC;
                end
            end
            S_LEFT: begin
                if (last_acc) state_d = up_f_q ? S_UP : S_CALC;
            end
            S_UP: begin
                if (last_acc) state_d = S_CALC;
            end
            S_CALC: state_d = S_OUT;
            S_OUT: begin
                if (bus.avg_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Rounded edge means; the sum cannot exceed N * max sample, so ACC_W bits are enough.
    always_comb begin
        avg_l_c  = DATA_WIDTH'((acc_l_q + RND) >> LOG2_N);
        avg_u_c  = DATA_WIDTH'((acc_u_q + RND) >> LOG2_N);
        dc_sum   = {1'b0, avg_l_c} + {1'b0, avg_u_c} + (DATA_WIDTH + 1)'(1);
        avg_dc_c = DATA_WIDTH'(dc_sum >> 1);
    end

    // A missing edge is substituted by the other one; with neither, a flat default is used.
    always_comb begin
        avg_d = '0;
        case ({left_f_q, up_f_q})
            2'b11: begin
                avg_d.left = avg_l_c;
                avg_d.up   = avg_u_c;
                avg_d.dc   = avg_dc_c;
            end
            2'b10: begin
                avg_d.left = avg_l_c;
                avg_d.up   = avg_l_c;
                avg_d.dc   = avg_l_c;
            end
            2'b01: begin
                avg_d.left = avg_u_c;
                avg_d.up   = avg_u_c;
                avg_d.dc   = avg_u_c;
            end
            default: begin
                avg_d.left = DATA_WIDTH'(DC_DEFAULT);
                avg_d.up   = DATA_WIDTH'(DC_DEFAULT);
                avg_d.dc   = DATA_WIDTH'(DC_DEFAULT);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            acc_l_q  <= '0;
            acc_u_q  <= '0;
            left_f_q <= 1'b0;
            up_f_q   <= 1'b0;
            avg_q    <= '0;
        end else begin
            if ((state_q == S_IDLE) && bus.start) begin
                left_f_q <= bus.left_avail;
                up_f_q   <= bus.up_avail;
                acc_l_q  <= '0;
                acc_u_q  <= '0;
                cnt_q    <= '0;
            end
            // N is a power of two, so the natural counter wrap lands on the Nth accept.
            if (accept) begin
                cnt_q <= cnt_q + LOG2_N'(1);
                if (state_q == S_LEFT) acc_l_q <= acc_l_q + smp_ext;
                else                   acc_u_q <= acc_u_q + smp_ext;
            end
            if (state_q == S_CALC) begin
                avg_q <= avg_d;
            end
        end
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.edge_sel       = (state_q == S_UP);
    assign bus.smp_ready      = smp_rdy;
    assign bus.avg_valid      = (state_q == S_OUT);
    assign bus.avg_y_left_out = avg_q.left;
    assign bus.avg_y_up_out   = avg_q.up;
    assign bus.avg_y_dc_out   = avg_q.dc;
endmodule

// File: tb/tb_cs_pred_seq.sv
// Bench for cs_pred_seq: directed vector table, hand-written corner sequences and
// randomized blocks compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cs_pred_seq;
    typedef int arr8_t [8];

    typedef struct {
        bit la;
        bit ua;
        int l_base;
        int l_last;
        int u_base;
        int u_last;
        int e_left;
        int e_up;
        int e_dc;
        int e_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cs_pred_seq_if #(.DATA_WIDTH(8)) bus();

    cs_pred_seq #(
        .DATA_WIDTH(8),
        .LOG2_N(3),
        .DC_DEFAULT(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain sums and integer rounding straight from the averaging rules.
    task automatic model(input bit la, input bit ua, input arr8_t l, input arr8_t u,
                         output int el, output int eu, output int ed);
        int sl, su, al, au;
        sl = 0;
        su = 0;
        for (int k = 0; k < 8; k++) begin
            sl += l[k];
            su += u[k];
        end
        al = (sl + 4) / 8;
        au = (su + 4) / 8;
        if (la && ua) begin
            el = al; eu = au; ed = (al + au + 1) / 2;
        end else if (la) begin
            el = al; eu = al; ed = al;
        end else if (ua) begin
            el = au; eu = au; ed = au;
        end else begin
            el = 128; eu = 128; ed = 128;
        end
    endtask

    task automatic run_block(input bit la, input bit ua, input arr8_t l, input arr8_t u,
                             input int stall, input bit poke,
                             output int lat, output int nl, output int nu, output bit saw_rdy);
        int t;
        int order_err;
        bit v, rdy, es;
        bus.start      = 1'b1;
        bus.left_avail = la;
        bus.up_avail   = ua;
        cyc();
        bus.start      = 1'b0;
        bus.left_avail = 1'b0;
        bus.up_avail   = 1'b0;
        t = 1;
        nl = 0;
        nu = 0;
        saw_rdy = 1'b0;
        order_err = 0;
        while (bus.avg_valid !== 1'b1 && t < 400) begin
            v   = ($urandom_range(99) >= stall);
            rdy = bus.smp_ready;
            es  = bus.edge_sel;
            if (rdy) saw_rdy = 1'b1;
            bus.smp_valid  = v;
            bus.smp_data   = es ? 8'(u[nu < 8 ? nu : 0]) : 8'(l[nl < 8 ? nl : 0]);
            bus.start      = poke && (t == 3);
            bus.left_avail = !la;
            bus.up_avail   = !ua;
            cyc();
            if (v && rdy) begin
                if (es) begin
                    nu++;
                    if (la && nl != 8) order_err++;
                end else begin
                    nl++;
                end
            end
            t++;
        end
        bus.smp_valid  = 1'b0;
        bus.start      = 1'b0;
        bus.left_avail = 1'b0;
        bus.up_avail   = 1'b0;
        lat = t;
        chk("avg_valid_timeout", int'(t < 400), 1);
        chk("edge_order", order_err, 0);
    endtask

    task automatic ack_and_check(input string tag, input int el, input int eu, input int ed,
                                 input int hold);
        for (int k = 0; k < hold; k++) begin
            cyc();
            chk({tag, "_hold_valid"}, int'(bus.avg_valid), 1);
        end
        chk({tag, "_left"}, int'(bus.avg_y_left_out), el);
        chk({tag, "_up"},   int'(bus.avg_y_up_out),   eu);
        chk({tag, "_dc"},   int'(bus.avg_y_dc_out),   ed);
        bus.avg_ack = 1'b1;
        cyc();
        bus.avg_ack = 1'b0;
        chk({tag, "_ack_valid"}, int'(bus.avg_valid), 0);
        chk({tag, "_ack_busy"},  int'(bus.busy), 0);
        chk({tag, "_idle_left"}, int'(bus.avg_y_left_out), el);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      int'(bus.busy), 0);
        chk({tag, "_smp_ready"}, int'(bus.smp_ready), 0);
        chk({tag, "_edge_sel"},  int'(bus.edge_sel), 0);
        chk({tag, "_avg_valid"}, int'(bus.avg_valid), 0);
        chk({tag, "_left"},      int'(bus.avg_y_left_out), 0);
        chk({tag, "_up"},        int'(bus.avg_y_up_out), 0);
        chk({tag, "_dc"},        int'(bus.avg_y_dc_out), 0);
    endtask

    initial begin
        vec_t  vt [7];
        arr8_t l, u;
        int    lat, nl, nu;
        bit    saw;
        int    el, eu, ed;
        bit    la, ua;

        vt[0] = '{1'b1, 1'b1, 100, 100, 200, 200, 100, 200, 150, 18};
        vt[1] = '{1'b1, 1'b1,   0,   3, 255, 255,   0, 255, 128, 18};
        vt[2] = '{1'b1, 1'b1,   0,   4, 255, 255,   1, 255, 128, 18};
        vt[3] = '{1'b0, 1'b1,   0,   0,  60,  60,  60,  60,  60, 10};
        vt[4] = '{1'b1, 1'b0,  77,  77,   0,   0,  77,  77,  77, 10};
        vt[5] = '{1'b0, 1'b0,   5,   5,   5,   5, 128, 128, 128,  2};
        vt[6] = '{1'b1, 1'b1,  40,  40,  80,  80,  40,  80,  60, 18};

        bus.start      = 1'b0;
        bus.left_avail = 1'b0;
        bus.up_avail   = 1'b0;
        bus.smp_valid  = 1'b0;
        bus.smp_data   = '0;
        bus.avg_ack    = 1'b0;
        rst = 1'b1;
        cyc();
        cyc();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed vectors, issued back-to-back with ack in the first OUT cycle.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 8; k++) begin
                l[k] = (k == 7) ? vt[i].l_last : vt[i].l_base;
                u[k] = (k == 7) ? vt[i].u_last : vt[i].u_base;
            end
            run_block(vt[i].la, vt[i].ua, l, u, 0, 1'b0, lat, nl, nu, saw);
            chk($sformatf("vec%0d_latency", i), lat, vt[i].e_lat);
            chk($sformatf("vec%0d_left_accepts", i), nl, vt[i].la ? 8 : 0);
            chk($sformatf("vec%0d_up_accepts", i), nu, vt[i].ua ? 8 : 0);
            chk($sformatf("vec%0d_saw_ready", i), int'(saw), int'(vt[i].la | vt[i].ua));
            ack_and_check($sformatf("vec%0d", i), vt[i].e_left, vt[i].e_up, vt[i].e_dc, 0);
        end

        // Start poked during LEFT, then held in OUT for 20 cycles with another start poke.
        for (int k = 0; k < 8; k++) begin
            l[k] = 100;
            u[k] = 200;
        end
        run_block(1'b1, 1'b1, l, u, 0, 1'b1, lat, nl, nu, saw);
        chk("poke_latency", lat, 18);
        for (int k = 0; k < 20; k++) begin
            bus.start = (k == 5);
            cyc();
            chk("hold_valid", int'(bus.avg_valid), 1);
            chk("hold_left",  int'(bus.avg_y_left_out), 100);
            chk("hold_up",    int'(bus.avg_y_up_out), 200);
            chk("hold_dc",    int'(bus.avg_y_dc_out), 150);
        end
        bus.start = 1'b0;
        ack_and_check("hold", 100, 200, 150, 0);

        // Reset after five left accepts.
        bus.start      = 1'b1;
        bus.left_avail = 1'b1;
        bus.up_avail   = 1'b1;
        cyc();
        bus.start      = 1'b0;
        bus.left_avail = 1'b0;
        bus.up_avail   = 1'b0;
        bus.smp_valid  = 1'b1;
        bus.smp_data   = 8'd33;
        for (int k = 0; k < 5; k++) cyc();
        chk("midrst_in_left", int'(bus.smp_ready), 1);
        bus.smp_valid = 1'b0;
        rst = 1'b1;
        cyc();
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            l[k] = 40;
            u[k] = 80;
        end
        run_block(1'b1, 1'b1, l, u, 0, 1'b0, lat, nl, nu, saw);
        chk("post_rst_latency", lat, 18);
        chk("post_rst_left_accepts", nl, 8);
        ack_and_check("post_rst", 40, 80, 60, 0);

        // Random blocks, each run with and without sample gaps.
        for (int i = 0; i < 15; i++) begin
            la = 1'($urandom_range(1));
            ua = 1'($urandom_range(1));
            for (int k = 0; k < 8; k++) begin
                l[k] = $urandom_range(255);
                u[k] = $urandom_range(255);
            end
            model(la, ua, l, u, el, eu, ed);
            for (int s = 0; s < 2; s++) begin
                run_block(la, ua, l, u, s * 50, 1'b0, lat, nl, nu, saw);
                if (s == 0) chk($sformatf("rnd%0d_latency", i), lat, (la ? 8 : 0) + (ua ? 8 : 0) + 2);
                chk($sformatf("rnd%0d_s%0d_left_accepts", i, s), nl, la ? 8 : 0);
                chk($sformatf("rnd%0d_s%0d_up_accepts", i, s), nu, ua ? 8 : 0);
                ack_and_check($sformatf("rnd%0d_s%0d", i, s), el, eu, ed, $urandom_range(3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
